// File: rtl/reg_file_pkg.sv
// Shared defaults for the reg_file register file.
// Optional macro REG_FILE_BYPASS_EN selects write-first on same-address read/write collisions.
package reg_file_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_DEPTH = 16;

  // Reset image for entries and read data; replicated per bit to fit any WIDTH.
  localparam logic [DEFAULT_WIDTH-1:0] RESET_DATA = '0;

endpackage

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file: one synchronous write port, one registered read port with valid.
// Macro REG_FILE_BYPASS_EN: defined = write-first on collision, undefined = read-before-write.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int  WIDTH  = DEFAULT_WIDTH,
  parameter int  DEPTH  = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic              RdEn,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic [WIDTH-1:0]  RdData,
  output logic              RdValid
);

  localparam logic [WIDTH-1:0]  RST_VAL = {WIDTH{RESET_DATA[0]}};
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_ok;
  logic             rd_req;
  logic             rd_in_range;

  // DEPTH need not be a power of two, so addresses are range-checked explicitly.
  assign wr_ok       = En && WrEn && ({1'b0, WrAddr} < DEPTH_C);
  assign rd_req      = En && RdEn;
  assign rd_in_range = ({1'b0, RdAddr} < DEPTH_C);

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_req) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_in_range ? mem_q[RdAddr] : RST_VAL;
`ifdef REG_FILE_BYPASS_EN
      if (wr_ok && (WrAddr == RdAddr)) begin
        rd_data_d = WrData;
      end
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_VAL;
      end
      rd_data_q  <= RST_VAL;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_q[WrAddr] <= WrData;
      end
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign RdData  = rd_data_q;
  assign RdValid = rd_valid_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file (WIDTH=64, DEPTH=10) against a per-cycle behavioural model.
module tb_reg_file;

  localparam int W = 64;
  localparam int D = 10;
  localparam int AW = $clog2(D);

  logic          Clk = 1'b0;
  logic          Rst, En, WrEn, RdEn;
  logic [AW-1:0] WrAddr, RdAddr;
  logic [W-1:0]  WrData;
  logic [W-1:0]  RdData;
  logic          RdValid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] model_mem [D];
  logic [W-1:0] exp_data;
  logic         exp_valid;

  reg_file #(.WIDTH(W), .DEPTH(D)) dut (
    .Clk(Clk), .Rst(Rst), .En(En),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEn(RdEn), .RdAddr(RdAddr),
    .RdData(RdData), .RdValid(RdValid)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: apply inputs, advance the model by the rules, compare just after the edge.
  task automatic step(input logic rst, input logic en,
                      input logic we, input int wa, input logic [W-1:0] wd,
                      input logic re, input int ra, input string tag);
    logic [W-1:0] rd_val;
    Rst = rst; En = en; WrEn = we; WrAddr = AW'(wa); WrData = wd;
    RdEn = re; RdAddr = AW'(ra);
    @(posedge Clk);
    if (rst) begin
      foreach (model_mem[i]) model_mem[i] = '0;
      exp_data  = '0;
      exp_valid = 1'b0;
    end else if (!en) begin
      exp_valid = 1'b0;
    end else begin
      if (re) begin
        rd_val = (ra < D) ? model_mem[ra] : '0;
`ifdef REG_FILE_BYPASS_EN
        if (we && wa == ra && wa < D) rd_val = wd;
`endif
        exp_data  = rd_val;
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      if (we && wa < D) model_mem[wa] = wd;
    end
    #1;
    check({tag, ".valid"}, W'(RdValid), W'(exp_valid));
    check({tag, ".data"}, RdData, exp_data);
  endtask

  initial begin
    logic [W-1:0] before_en;
    Rst = 1'b1; En = 1'b0; WrEn = 1'b0; RdEn = 1'b0;
    WrAddr = '0; RdAddr = '0; WrData = '0;
    foreach (model_mem[i]) model_mem[i] = '0;
    exp_data = '0; exp_valid = 1'b0;

    // Reset clear, then sweep every entry
    step(1, 0, 0, 0, '0, 0, 0, "reset");
    for (int a = 0; a < D; a++) step(0, 1, 0, 0, '0, 1, a, "rst_sweep");

    // Write then read
    step(0, 1, 1, 5, 64'hDEAD_BEEF_0123_4567, 0, 0, "wr5");
    step(0, 1, 0, 0, '0, 1, 5, "rd5");
    check("rd5_const", RdData, 64'hDEAD_BEEF_0123_4567);
    step(0, 1, 0, 0, '0, 0, 0, "idle");
    check("idle_valid_low", W'(RdValid), '0);

    // Same-address collision
    step(0, 1, 1, 3, 64'h1, 0, 0, "wr3");
    step(0, 1, 1, 3, 64'h2, 1, 3, "collide3");
`ifdef REG_FILE_BYPASS_EN
    check("collide_const", RdData, 64'h2);
`else
    check("collide_const", RdData, 64'h1);
`endif
    step(0, 1, 0, 0, '0, 1, 3, "rd3_after");
    check("rd3_after_const", RdData, 64'h2);

    // En gating: no write, RdValid low, RdData holds
    before_en = RdData;
    step(0, 0, 1, 7, 64'hFF, 1, 7, "en_low");
    check("en_low_hold", RdData, before_en);
    step(0, 1, 0, 0, '0, 1, 7, "rd7");
    check("rd7_const", RdData, 64'h0);

    // Out of range write/read
    step(0, 1, 1, 12, 64'hAA, 0, 0, "wr12");
    step(0, 1, 0, 0, '0, 1, 12, "rd12");
    check("rd12_const", RdData, 64'h0);
    for (int a = 0; a < D; a++) step(0, 1, 0, 0, '0, 1, a, "oor_sweep");

    // Randomized traffic, including collisions, out-of-range and rare resets
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), {$urandom, $urandom},
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), "rand");
    end

    // Reset mid-stream: write in the reset cycle must be discarded
    step(0, 1, 1, 4, 64'h1234, 1, 1, "pre_rst_a");
    step(0, 1, 0, 0, '0, 1, 4, "pre_rst_b");
    step(1, 1, 1, 4, 64'h5555, 1, 4, "mid_rst");
    check("mid_rst_valid_const", W'(RdValid), '0);
    check("mid_rst_data_const", RdData, '0);
    step(0, 1, 0, 0, '0, 1, 4, "post_rst_rd4");
    check("post_rst_rd4_const", RdData, '0);
    for (int a = 0; a < D; a++) step(0, 1, 0, 0, '0, 1, a, "post_rst_sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
